write_req_gen: RTL and testbench

WRITE_REQ_GEN -- requirements
Module: write_req_gen

---
 rtl/write_req_gen.sv | 149 ++++++++++++++
 tb/tb_write_req_gen.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/write_req_gen.sv
// Write request generator: issues num_lines 64B writes with a seeded data pattern and
// tracks outstanding writes by snooping the B channel for its own ID prefix.
module write_req_gen #(
    parameter logic [3:0]  ID_PREFIX = 4'h0,
    parameter int unsigned MAX_OUT   = 16,
    parameter logic [5:0]  AWUSER    = 6'h0
) (
    input  logic         axi4_mm_clk,
    input  logic         axi4_mm_rst,
    input  logic         start,
    input  logic [63:0]  base_addr,
    input  logic [15:0]  num_lines,
    input  logic [31:0]  seed,
    output logic         busy,
    output logic         done,
    output logic         err,
    output logic         awvalid,
    input  logic         awready,
    output logic [63:0]  awaddr,
    output logic [11:0]  awid,
    output logic [5:0]   awuser,
    output logic         wvalid,
    input  logic         wready,
    output logic [511:0] wdata,
    output logic [63:0]  wstrb,
    output logic         wlast,
    input  logic         bvalid,
    input  logic [11:0]  bid,
    input  logic [1:0]   bresp
);

    typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

    localparam logic [4:0] MaxOut = 5'(MAX_OUT);

    state_e       state_q, state_d;
    logic [15:0]  num_q, num_d;
    logic [15:0]  issued_q, issued_d;
    logic [4:0]   out_q, out_d;
    logic [63:0]  addr_q, addr_d;
    logic [31:0]  word_q, word_d;
    logic         valid_q, valid_d;
    logic         err_q, err_d;
    logic         done_q, done_d;
    logic         accept;
    logic         cmpl;

    assign accept = valid_q & awready & wready;
    assign cmpl   = bvalid && (bid[11:8] == ID_PREFIX);

    always_comb begin
        state_d  = state_q;
        num_d    = num_q;
        issued_d = issued_q;
        out_d    = out_q;
        addr_d   = addr_q;
        word_d   = word_q;
        err_d    = err_q;
        done_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    num_d    = num_lines;
                    issued_d = 16'd0;
                    addr_d   = base_addr;
                    word_d   = seed;
                    err_d    = 1'b0;
                    state_d  = (num_lines == 16'd0) ? StDone : StIssue;
                end
            end
            StIssue: begin
                if (accept) begin
                    issued_d = issued_q + 16'd1;
                    addr_d   = addr_q + 64'd64;
                    word_d   = word_q + 32'd1;
                    if (issued_d == num_q) begin
                        state_d = StDrain;
                    end
                end
            end
            StDrain: begin
                if (out_q == 5'd0) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                done_d  = 1'b1;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        // Completion bookkeeping runs in every state so stray responses are flagged.
        if (cmpl && (bresp != 2'b00)) begin
            err_d = 1'b1;
        end
        case ({accept, cmpl})
            2'b10: out_d = out_q + 5'd1;
            2'b01: begin
                if (out_q == 5'd0) begin
                    err_d = 1'b1;
                end else begin
                    out_d = out_q - 5'd1;
                end
            end
            default: out_d = out_q;
        endcase

        valid_d = (state_d == StIssue) && (issued_d < num_d) && (out_d < MaxOut);
    end

    always_ff @(posedge axi4_mm_clk) begin
        if (axi4_mm_rst) begin
            state_q  <= StIdle;
            num_q    <= 16'd0;
            issued_q <= 16'd0;
            out_q    <= 5'd0;
            addr_q   <= 64'd0;
            word_q   <= 32'd0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            num_q    <= num_d;
            issued_q <= issued_d;
            out_q    <= out_d;
            addr_q   <= addr_d;
            word_q   <= word_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            done_q   <= done_d;
        end
    end

    assign busy    = (state_q != StIdle);
    assign done    = done_q;
    assign err     = err_q;
    assign awvalid = valid_q;
    assign wvalid  = valid_q;
    assign awaddr  = addr_q;
    assign awid    = {ID_PREFIX, issued_q[7:0]};
    assign awuser  = AWUSER;
    assign wdata   = {16{word_q}};
    assign wstrb   = '1;
    assign wlast   = 1'b1;

endmodule

// File: tb/tb_write_req_gen.sv
// Directed self-checking bench for write_req_gen (MAX_OUT=2 to exercise back-pressure).
module tb_write_req_gen;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [63:0]  base_addr;
    logic [15:0]  num_lines;
    logic [31:0]  seed;
    logic         busy, done, err;
    logic         awvalid, awready;
    logic [63:0]  awaddr;
    logic [11:0]  awid;
    logic [5:0]   awuser;
    logic         wvalid, wready;
    logic [511:0] wdata;
    logic [63:0]  wstrb;
    logic         wlast;
    logic         bvalid;
    logic [11:0]  bid;
    logic [1:0]   bresp;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    write_req_gen #(
        .ID_PREFIX(4'h0),
        .MAX_OUT  (2),
        .AWUSER   (6'h2A)
    ) dut (
        .axi4_mm_clk(clk),
        .axi4_mm_rst(rst),
        .start      (start),
        .base_addr  (base_addr),
        .num_lines  (num_lines),
        .seed       (seed),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .awvalid    (awvalid),
        .awready    (awready),
        .awaddr     (awaddr),
        .awid       (awid),
        .awuser     (awuser),
        .wvalid     (wvalid),
        .wready     (wready),
        .wdata      (wdata),
        .wstrb      (wstrb),
        .wlast      (wlast),
        .bvalid     (bvalid),
        .bid        (bid),
        .bresp      (bresp)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_cmd(input logic [63:0] b, input logic [15:0] n, input logic [31:0] s);
        start = 1'b1;
        base_addr = b;
        num_lines = n;
        seed = s;
        tick();
        start = 1'b0;
    endtask

    task automatic accept_pulse();
        awready = 1'b1;
        wready  = 1'b1;
        tick();
        awready = 1'b0;
        wready  = 1'b0;
    endtask

    task automatic b_pulse(input logic [11:0] id, input logic [1:0] resp);
        bvalid = 1'b1;
        bid    = id;
        bresp  = resp;
        tick();
        bvalid = 1'b0;
        bid    = 12'h0;
        bresp  = 2'b00;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!awvalid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 512'(awvalid), 512'(1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        int done_cnt;
        int done_at;
        logic [31:0] w;

        rst = 1'b1; start = 1'b0; base_addr = '0; num_lines = '0; seed = '0;
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0; bid = '0; bresp = '0;
        tick(); tick();
        rst = 1'b0;

        // Reset state
        check("rst_busy",   512'(busy),    512'(0));
        check("rst_done",   512'(done),    512'(0));
        check("rst_err",    512'(err),     512'(0));
        check("rst_awv",    512'(awvalid), 512'(0));
        check("rst_wv",     512'(wvalid),  512'(0));
        check("rst_awaddr", 512'(awaddr),  512'(0));
        check("rst_wdata",  wdata,         512'(0));
        check("rst_awuser", 512'(awuser),  512'(6'h2A));
        check("rst_wstrb",  512'(wstrb),   512'(64'hFFFF_FFFF_FFFF_FFFF));
        check("rst_wlast",  512'(wlast),   512'(1));

        // Basic 3-line command, ready every other cycle
        start_cmd(64'h1000, 16'd3, 32'd5);
        check("t1_latency", 512'(awvalid), 512'(1));
        check("t1_busy",    512'(busy),    512'(1));
        for (int i = 0; i < 3; i++) begin
            wait_valid("t1_wait");
            w = 32'd5 + 32'(i);
            check("t1_awaddr", 512'(awaddr), 512'(64'h1000 + 64'(64 * i)));
            check("t1_awid",   512'(awid),   512'(12'(i)));
            check("t1_wdata",  wdata,        {16{w}});
            check("t1_wvalid", 512'(wvalid), 512'(1));
            accept_pulse();
            b_pulse(12'h000, 2'b00);
        end
        check("t1_drain_awv", 512'(awvalid), 512'(0));
        done_cnt = 0;
        done_at  = 0;
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (done) begin
                done_cnt++;
                if (done_at == 0) done_at = k;
            end
        end
        check("t1_done_cnt", 512'(done_cnt), 512'(1));
        check("t1_done_at",  512'(done_at),  512'(2));
        check("t1_err",      512'(err),      512'(0));
        check("t1_idle",     512'(busy),     512'(0));

        // Zero-length command
        start_cmd(64'h5000, 16'd0, 32'd9);
        check("t2_awv0",  512'(awvalid), 512'(0));
        check("t2_busy",  512'(busy),    512'(1));
        check("t2_done0", 512'(done),    512'(0));
        tick();
        check("t2_done1", 512'(done),    512'(1));
        check("t2_awv1",  512'(awvalid), 512'(0));
        tick();
        check("t2_done2", 512'(done),    512'(0));

        // Outstanding limit, simultaneous B+accept, foreign and error responses
        start_cmd(64'h2000, 16'd4, 32'h100);
        check("t3_v0", 512'(awvalid), 512'(1));
        accept_pulse();
        check("t3_v1",    512'(awvalid), 512'(1));
        check("t3_addr1", 512'(awaddr),  512'(64'h2040));
        accept_pulse();
        check("t3_stall", 512'(awvalid), 512'(0));
        accept_pulse();
        tick();
        check("t3_stall2",    512'(awvalid), 512'(0));
        check("t3_no_accept", 512'(awaddr),  512'(64'h2080));
        b_pulse(12'h000, 2'b00);
        check("t3_resume", 512'(awvalid), 512'(1));
        check("t3_addr2",  512'(awaddr),  512'(64'h2080));
        check("t3_id2",    512'(awid),    512'(12'h002));
        awready = 1'b1; wready = 1'b1; bvalid = 1'b1; bid = 12'h000; bresp = 2'b00;
        tick();
        awready = 1'b0; wready = 1'b0; bvalid = 1'b0;
        check("t3_both_v",  512'(awvalid), 512'(1));
        check("t3_addr3",   512'(awaddr),  512'(64'h20C0));
        check("t3_wdata3",  wdata,         {16{32'h103}});
        accept_pulse();
        check("t3_drain", 512'(awvalid), 512'(0));
        b_pulse(12'h500, 2'b00);
        b_pulse(12'h000, 2'b10);
        check("t3_err_set", 512'(err), 512'(1));
        tick(); tick(); tick();
        check("t3_foreign_ignored", 512'(busy), 512'(1));
        b_pulse(12'h000, 2'b00);
        tick(); tick();
        check("t3_done",     512'(done), 512'(1));
        check("t3_err_done", 512'(err),  512'(1));
        tick();
        check("t3_err_hold", 512'(err),  512'(1));

        // Address wrap at 2^64; start clears err
        start_cmd(64'hFFFF_FFFF_FFFF_FFC0, 16'd2, 32'hFFFF_FFFF);
        check("t4_err_clr", 512'(err),    512'(0));
        check("t4_addr0",   512'(awaddr), 512'(64'hFFFF_FFFF_FFFF_FFC0));
        check("t4_wdata0",  wdata,        {16{32'hFFFF_FFFF}});
        accept_pulse();
        check("t4_addr1",  512'(awaddr), 512'(64'h0));
        check("t4_id1",    512'(awid),   512'(12'h001));
        check("t4_wdata1", wdata,        512'(0));
        accept_pulse();
        check("t4_drain", 512'(awvalid), 512'(0));
        b_pulse(12'h000, 2'b00);
        b_pulse(12'h001, 2'b00);
        tick(); tick();
        check("t4_done", 512'(done), 512'(1));
        check("t4_err",  512'(err),  512'(0));
        tick();

        // Reset mid-command, then a stray response
        start_cmd(64'h3000, 16'd5, 32'h0);
        accept_pulse();
        accept_pulse();
        check("t5_stall", 512'(awvalid), 512'(0));
        check("t5_busy",  512'(busy),    512'(1));
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("t5_busy0",   512'(busy),    512'(0));
        check("t5_awv0",    512'(awvalid), 512'(0));
        check("t5_wv0",     512'(wvalid),  512'(0));
        check("t5_err0",    512'(err),     512'(0));
        check("t5_done0",   512'(done),    512'(0));
        check("t5_awaddr0", 512'(awaddr),  512'(0));
        check("t5_awid0",   512'(awid),    512'(0));
        check("t5_wdata0",  wdata,         512'(0));
        check("t5_awuser",  512'(awuser),  512'(6'h2A));
        b_pulse(12'h000, 2'b00);
        check("t5_stray_err", 512'(err),     512'(1));
        check("t5_stray_awv", 512'(awvalid), 512'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
